// File: rtl/ex_div.sv
// ex_div: multi-cycle RV32M divider (DIV/DIVU/REM/REMU) for the EX stage.
// One restoring shift-subtract step per clock; holds the pipeline via busy_o
// and issues a single-cycle register-file write-back on completion.
module ex_div #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic [4:0]      reg_waddr_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            ready_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      reg_waddr_o,
  output logic [XLEN-1:0] reg_wdata_o,
  output logic            reg_wen_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_CALC  = 2'd2,
    S_END   = 2'd3
  } state_e;

  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(XLEN - 1);

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [4:0]        rd_q, rd_d;
  logic [XLEN-1:0]   quot_q, quot_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   den_q, den_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              negq_q, negq_d;
  logic              negr_q, negr_d;
  logic              busy_q, busy_d;
  logic              ready_q, ready_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [4:0]        waddr_q, waddr_d;

  logic              is_signed;
  logic [XLEN-1:0]   abs_a;
  logic [XLEN-1:0]   abs_b;
  logic [XLEN:0]     shift_w;
  logic              sub_ok;
  logic [XLEN-1:0]   q_fix;
  logic [XLEN-1:0]   r_fix;

  // Operand magnitudes, shifted partial remainder and final sign correction
  assign is_signed = ~op_q[0];
  assign abs_a     = (is_signed && a_q[XLEN-1]) ? XLEN'(-a_q) : a_q;
  assign abs_b     = (is_signed && b_q[XLEN-1]) ? XLEN'(-b_q) : b_q;
  assign shift_w   = {rem_q, quot_q[XLEN-1]};
  assign sub_ok    = (shift_w >= {1'b0, den_q});
  assign q_fix     = negq_q ? XLEN'(-quot_q) : quot_q;
  assign r_fix     = negr_q ? XLEN'(-rem_q) : rem_q;

  // Next-state, datapath and output computation
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    rd_d     = rd_q;
    quot_d   = quot_q;
    rem_d    = rem_q;
    den_d    = den_q;
    cnt_d    = cnt_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    busy_d   = busy_q;
    ready_d  = 1'b0;
    result_d = result_q;
    waddr_d  = waddr_q;

    case (state_q)
      S_IDLE: begin
        // A flush in the same cycle suppresses the request
        if (start_i && !flush_i) begin
          op_d    = op_i;
          a_d     = dividend_i;
          b_d     = divisor_i;
          rd_d    = reg_waddr_i;
          busy_d  = 1'b1;
          state_d = S_START;
        end
      end

      S_START: begin
        if (flush_i) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (b_q == '0) begin
          quot_d  = ALL_ONES;
          rem_d   = a_q;
          negq_d  = 1'b0;
          negr_d  = 1'b0;
          state_d = S_END;
        end else if (is_signed && (a_q == MIN_NEG) && (b_q == ALL_ONES)) begin
          quot_d  = MIN_NEG;
          rem_d   = '0;
          negq_d  = 1'b0;
          negr_d  = 1'b0;
          state_d = S_END;
        end else begin
          quot_d  = abs_a;
          den_d   = abs_b;
          rem_d   = '0;
          cnt_d   = '0;
          negq_d  = is_signed & (a_q[XLEN-1] ^ b_q[XLEN-1]);
          negr_d  = is_signed & a_q[XLEN-1];
          state_d = S_CALC;
        end
      end

      S_CALC: begin
        if (flush_i) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          // Restoring step: quotient bits shift out of quot into rem
          quot_d = {quot_q[XLEN-2:0], sub_ok};
          rem_d  = sub_ok ? XLEN'(shift_w - {1'b0, den_q}) : shift_w[XLEN-1:0];
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_IT) begin
            state_d = S_END;
          end
        end
      end

      S_END: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
        if (!flush_i) begin
          result_d = op_q[1] ? r_fix : q_fix;
          waddr_d  = rd_q;
          ready_d  = 1'b1;
        end
      end

      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rd_q     <= '0;
      quot_q   <= '0;
      rem_q    <= '0;
      den_q    <= '0;
      cnt_q    <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
      result_q <= '0;
      waddr_q  <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rd_q     <= rd_d;
      quot_q   <= quot_d;
      rem_q    <= rem_d;
      den_q    <= den_d;
      cnt_q    <= cnt_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
      result_q <= result_d;
      waddr_q  <= waddr_d;
    end
  end

  assign busy_o      = busy_q;
  assign ready_o     = ready_q;
  assign result_o    = result_q;
  assign reg_waddr_o = waddr_q;
  assign reg_wdata_o = result_q;
  assign reg_wen_o   = ready_q;

endmodule

// File: tb/tb_ex_div.sv
// tb_ex_div: vector table, random ops against an arithmetic reference model,
// and hand-written busy/flush/reset sequences for ex_div.
module tb_ex_div;

  localparam logic [31:0] MIN_NEG = 32'h8000_0000;
  localparam logic [31:0] ONES    = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic [4:0]  reg_waddr_i;
  logic        flush_i;
  logic        busy_o;
  logic        ready_o;
  logic [31:0] result_o;
  logic [4:0]  reg_waddr_o;
  logic [31:0] reg_wdata_o;
  logic        reg_wen_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  always #5 clk = ~clk;

  ex_div #(.XLEN(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
    .dividend_i(dividend_i), .divisor_i(divisor_i), .reg_waddr_i(reg_waddr_i),
    .flush_i(flush_i), .busy_o(busy_o), .ready_o(ready_o), .result_o(result_o),
    .reg_waddr_o(reg_waddr_o), .reg_wdata_o(reg_wdata_o), .reg_wen_o(reg_wen_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // RISC-V M-extension semantics expressed with plain language arithmetic
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return op[1] ? a : ONES;
    if (!op[0] && a == MIN_NEG && b == ONES) return op[1] ? 32'd0 : MIN_NEG;
    case (op)
      2'd0:    return 32'(sa / sb);
      2'd1:    return a / b;
      2'd2:    return 32'(sa % sb);
      default: return a % b;
    endcase
  endfunction

  // Issue one operation and check latency, write-back and single-cycle pulse.
  // Called and returns 1 time unit after a rising edge.
  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp, input int lat);
    int n;
    bit got;
    bit busy_drop;
    start_i = 1'b1; op_i = op; dividend_i = a; divisor_i = b; reg_waddr_i = rd;
    @(posedge clk); #1;
    start_i = 1'b0;
    dividend_i = $urandom; divisor_i = $urandom;
    check({name, "_busy_set"}, 32'(busy_o), 32'd1);
    n = 0; got = 0; busy_drop = 0;
    while (n < 100 && !got) begin
      @(posedge clk); #1;
      n++;
      if (ready_o) got = 1;
      else if (!busy_o) busy_drop = 1;
    end
    check({name, "_latency"}, 32'(n), 32'(lat));
    check({name, "_busy_held"}, 32'(busy_drop), 32'd0);
    check({name, "_result"}, result_o, exp);
    check({name, "_wdata"}, reg_wdata_o, exp);
    check({name, "_waddr"}, 32'(reg_waddr_o), 32'(rd));
    check({name, "_wen"}, 32'(reg_wen_o), 32'd1);
    check({name, "_busy_clr"}, 32'(busy_o), 32'd0);
    @(posedge clk); #1;
    check({name, "_pulse_end"}, 32'({ready_o, reg_wen_o}), 32'd0);
    check({name, "_hold"}, result_o, exp);
  endtask

  initial begin
    vec_t vecs[10];
    logic [31:0] prev_res;
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    int          rl;

    vecs[0] = '{2'd0, 32'd100,      32'd7,  5'd3,  32'd14,         34};
    vecs[1] = '{2'd2, 32'd100,      32'd7,  5'd4,  32'd2,          34};
    vecs[2] = '{2'd0, 32'hFFFFFF9C, 32'd7,  5'd5,  32'hFFFFFFF2,   34};
    vecs[3] = '{2'd2, 32'hFFFFFF9C, 32'd7,  5'd6,  32'hFFFFFFFE,   34};
    vecs[4] = '{2'd1, ONES,         32'd2,  5'd7,  32'h7FFFFFFF,   34};
    vecs[5] = '{2'd3, ONES,         32'd2,  5'd8,  32'd1,          34};
    vecs[6] = '{2'd0, 32'd5,        32'd0,  5'd9,  ONES,           2};
    vecs[7] = '{2'd2, 32'd5,        32'd0,  5'd10, 32'd5,          2};
    vecs[8] = '{2'd0, MIN_NEG,      ONES,   5'd0,  MIN_NEG,        2};
    vecs[9] = '{2'd2, MIN_NEG,      ONES,   5'd31, 32'd0,          2};

    rst = 1'b0; start_i = 1'b0; op_i = '0; dividend_i = '0; divisor_i = '0;
    reg_waddr_i = '0; flush_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy_o), 32'd0);
    check("reset_ready", 32'(ready_o), 32'd0);
    check("reset_result", result_o, 32'd0);
    check("reset_waddr", 32'(reg_waddr_o), 32'd0);
    check("reset_wen", 32'(reg_wen_o), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd,
             vecs[i].exp, vecs[i].lat);
    end

    for (int i = 0; i < 60; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = ($urandom_range(0, 9) == 0) ? MIN_NEG : 32'($urandom);
      case ($urandom_range(0, 9))
        0:       rb = 32'd0;
        1:       rb = ONES;
        2:       rb = 32'($urandom_range(1, 15));
        default: rb = 32'($urandom);
      endcase
      rl = (rb == 32'd0 || (!rop[0] && ra == MIN_NEG && rb == ONES)) ? 2 : 34;
      run_op($sformatf("rnd%0d", i), rop, ra, rb, 5'($urandom_range(0, 31)),
             model(rop, ra, rb), rl);
    end

    // start_i held for 40 cycles: second op only sampled in the ready cycle
    start_i = 1'b1; op_i = 2'd1; dividend_i = 32'd100; divisor_i = 32'd7; reg_waddr_i = 5'd12;
    for (int k = 0; k < 80; k++) begin
      @(posedge clk); #1;
      check($sformatf("b2b_busy_e%0d", k), 32'(busy_o),
            32'((k < 34) || (k >= 35 && k < 69)));
      check($sformatf("b2b_ready_e%0d", k), 32'(ready_o), 32'(k == 34 || k == 69));
      if (k == 34 || k == 69) check($sformatf("b2b_res_e%0d", k), result_o, 32'd14);
      if (k == 39) start_i = 1'b0;
    end

    // flush in IDLE blocks a simultaneous start
    start_i = 1'b1; flush_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0; flush_i = 1'b0;
    check("idle_flush_busy", 32'(busy_o), 32'd0);
    @(posedge clk); #1;
    check("idle_flush_busy2", 32'(busy_o), 32'd0);

    // flush during CALC aborts without a write-back
    prev_res = result_o;
    start_i = 1'b1; op_i = 2'd0; dividend_i = 32'd1000; divisor_i = 32'd3; reg_waddr_i = 5'd2;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    check("flush_busy", 32'(busy_o), 32'd0);
    begin
      bit seen = 0;
      for (int k = 0; k < 40; k++) begin
        @(posedge clk); #1;
        if (ready_o || reg_wen_o || busy_o) seen = 1;
      end
      check("flush_no_ready", 32'(seen), 32'd0);
    end
    check("flush_result_kept", result_o, prev_res);
    run_op("after_flush_divu", 2'd1, 32'd9, 32'd3, 5'd13, 32'd3, 34);

    // synchronous reset mid-operation
    start_i = 1'b1; op_i = 2'd0; dividend_i = 32'd77; divisor_i = 32'd5; reg_waddr_i = 5'd14;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_busy", 32'(busy_o), 32'd0);
    check("midrst_ready", 32'(ready_o), 32'd0);
    check("midrst_result", result_o, 32'd0);
    check("midrst_wdata", reg_wdata_o, 32'd0);
    check("midrst_waddr", 32'(reg_waddr_o), 32'd0);
    check("midrst_wen", 32'(reg_wen_o), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("postrst_idle", 32'(busy_o), 32'd0);
    run_op("after_rst_div", 2'd0, 32'd8, 32'd2, 5'd15, 32'd4, 34);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_div.md
Name: ex_div

Overview:
- Multi-cycle RV32M divider in the EX stage, serving DIV, DIVU, REM and REMU.
- Performs one restoring shift-subtract iteration per clock.
- While busy, it holds the pipeline through a hold request to ctrl.
- On completion it drives a one-cycle write-back (address, data, enable) toward the register file write port.

Parameters:
- XLEN, 32, operand and result width.
- CNT_W, 6, iteration counter width; must hold XLEN.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-low
- start_i  input  1  request from EX; sampled only in IDLE
- op_i  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU
- dividend_i  input  XLEN  rs1 value
- divisor_i  input  XLEN  rs2 value
- reg_waddr_i  input  5  destination rd
- flush_i  input  1  branch/jump flush from ctrl; aborts the operation in flight
- busy_o  output  1  hold request to ctrl; high from the sampling edge until completion
- ready_o  output  1  one-cycle completion pulse
- result_o  output  XLEN  quotient or remainder; valid while ready_o=1
- reg_waddr_o  output  5  captured rd
- reg_wdata_o  output  XLEN  equals result_o
- reg_wen_o  output  1  equals ready_o

Behaviour:
- Reset (rst=0 at a clk edge):
  - state returns to IDLE;
  - all outputs and internal registers clear to 0;
  - reset takes priority over flush_i and start_i, including mid-operation.
- States and transitions:
  - IDLE:
    - on start_i=1, capture op, operands and rd; set busy_o=1; go to START.
    - start_i while not in IDLE is ignored; no queueing.
  - START, special cases (take priority):
    - divisor==0 -> quotient 0xFFFFFFFF, remainder = dividend; go to END.
    - signed op with dividend 0x80000000 and divisor 0xFFFFFFFF -> quotient 0x80000000, remainder 0; go to END.
  - START, normal path:
    - load |dividend| and |divisor| (absolute value only for signed ops);
    - clear the partial remainder; set counter to 0; go to CALC.
  - CALC, per edge:
    - shift {rem, quot} left by 1;
    - if the shifted rem >= divisor, subtract and set quot LSB = 1;
    - increment the counter; after XLEN iterations go to END.
  - END:
    - apply sign fix for signed ops: negate the quotient if operand signs differ; the remainder takes the dividend's sign;
    - select quotient (DIV/DIVU) or remainder (REM/REMU);
    - register result_o and set ready_o=1; clear busy_o; go to IDLE.
- Latency, counted from the edge that samples start_i:
  - normal path: ready_o=1 after edge 34 (1 START + 32 CALC + 1 END);
  - special cases: ready_o=1 after edge 2.
- Output timing:
  - ready_o and reg_wen_o stay high exactly one cycle.
  - result_o and reg_waddr_o hold their values until the next completion.
  - A new start_i in the same cycle that ready_o is high is accepted, since the state is already IDLE.
- Flush:
  - flush_i=1 in any non-IDLE state -> IDLE on the next edge;
  - busy_o=0; no ready_o pulse; result_o unchanged.
  - flush_i in IDLE has no effect and also blocks a start_i sampled in the same cycle.
- rd==0: write-back is still issued; the register file discards it.
- Widths: all arithmetic is XLEN+1 bits internally to keep the subtraction borrow; no overflow beyond the special case above.

Test Plan:
- DIV 100/7 -> result 14 after edge 34; REM 100/7 -> 2; reg_wen_o a single-cycle pulse with reg_waddr_o = captured rd.
- DIV -100/7 (0xFFFFFF9C, 7) -> 0xFFFFFFF2; REM -> 0xFFFFFFFE; DIVU 0xFFFFFFFF/2 -> 0x7FFFFFFF; REMU -> 1.
- DIV 5/0 -> 0xFFFFFFFF after edge 2; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0, both after edge 2.
- Busy/back-to-back: start_i held high for 40 cycles -> second op begins only in the ready_o cycle; busy_o high throughout the first op.
- Flush at edge 10 of CALC -> IDLE, no ready_o, busy_o=0; a following DIVU 9/3 -> 3.
- rst=0 at edge 20 mid-op -> all outputs 0, IDLE; after release DIV 8/2 -> 4.
